// File: rtl/forex_result_reader_if.sv
// rtl/forex_result_reader_if.sv - host register bus and container path stream bundle
//
// Groups the two traffic paths of the result reader:
//   host side : chipselect, read, write, address[2:0] in; readdata[31:0] out
//   path side : in_valid, in_node[NODE_W], in_last, in_weight[WEIGHT_W] in; in_ready out
// The master modport drives requests and beats. The slave modport is the reader.

interface forex_result_reader_if #(
    parameter int NODE_W   = 6,
    parameter int WEIGHT_W = 32
) ();
    logic                chipselect;
    logic                read;
    logic                write;
    logic [2:0]          address;
    logic [31:0]         readdata;

    logic                in_valid;
    logic [NODE_W-1:0]   in_node;
    logic                in_last;
    logic [WEIGHT_W-1:0] in_weight;
    logic                in_ready;

    modport master (
        output chipselect, read, write, address,
        output in_valid, in_node, in_last, in_weight,
        input  readdata, in_ready
    );

    modport slave (
        input  chipselect, read, write, address,
        input  in_valid, in_node, in_last, in_weight,
        output readdata, in_ready
    );
endinterface

// File: rtl/forex_result_reader.sv
// rtl/forex_result_reader.sv - buffers a detected negative cycle and returns it to the host
//
// Collects the path of the negative cycle detected by the container, one node
// per beat, into a FIFO. It then lets the host poll status and pop the nodes
// back in arrival order. It also keeps the total cycle weight and flags
// truncation when the path is longer than the buffer.
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : slave side of the register bus and the path stream.
//           readdata has a read latency of 1. in_ready is combinational.
// Register map (32-bit):
//   0 STATUS : {16'b0, count[7:0], 4'b0, collecting, empty, overflow, done}
//   1 POP    : head node (zero-extended) in DONE with count>0, else 32'hFFFF_FFFF
//   2 WEIGHT : cycle weight, sign-extended
//   3        : write = clear, read = 0
//   4..7     : read 0

module forex_result_reader #(
    parameter int NODE_W   = 6,
    parameter int WEIGHT_W = 32,
    parameter int DEPTH    = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    forex_result_reader_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                ready_int;

    logic [NODE_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [7:0]          count;
    logic                overflow;
    logic [WEIGHT_W-1:0] weight_reg;
    logic [31:0]         readdata_q;

    logic                clear;
    logic                accept;
    logic                store;
    logic                drop;
    logic                pop_ok;
    logic                pop;
    logic [31:0]         weight_ext;
    logic [31:0]         rd_mux;

    // Clear wins over any beat or pop presented in the same cycle.
    assign clear  = bus.chipselect && bus.write && (bus.address == 3'd3);
    assign accept = bus.in_valid && ready_int;
    assign store  = accept && !clear && (count < 8'(DEPTH));
    // A full buffer still consumes beats so the container can finish the
    // cycle. The tail is lost and the loss is flagged.
    assign drop   = accept && !clear && (count == 8'(DEPTH));
    assign pop_ok = (state == ST_DONE) && (count != 8'd0);
    assign pop    = bus.chipselect && bus.read && (bus.address == 3'd1)
                    && pop_ok && !clear;

    assign weight_ext   = 32'($signed(weight_reg));
    assign bus.in_ready = ready_int;
    assign bus.readdata = readdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_int  = 1'b0;
        case (state)
            ST_EMPTY: begin
                ready_int = 1'b1;
                if (bus.in_valid) begin
                    state_next = bus.in_last ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                ready_int = 1'b1;
                if (bus.in_valid && bus.in_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Stays here after the drain so the host can still see done.
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        if (clear) begin
            state_next = ST_EMPTY;
        end
        if (reset) begin
            ready_int = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= 8'd0;
            overflow   <= 1'b0;
            weight_reg <= '0;
            readdata_q <= 32'd0;
        end else begin
            if (clear) begin
                // weight_reg survives a clear on purpose. Only reset drops it.
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= 8'd0;
                overflow <= 1'b0;
            end else begin
                if (store) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    count  <= count + 8'd1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (accept && bus.in_last) begin
                    weight_reg <= bus.in_weight;
                end
                // Stores and pops are mutually exclusive by state.
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    count  <= count - 8'd1;
                end
            end
            if (bus.chipselect && bus.read) begin
                readdata_q <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store && !reset) begin
            mem[wr_ptr] <= bus.in_node;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (bus.address)
            3'd0: rd_mux = {16'd0, count, 4'd0, (state == ST_FILL),
                            (count == 8'd0), overflow, (state == ST_DONE)};
            3'd1: rd_mux = pop_ok ? 32'(mem[rd_ptr]) : 32'hFFFF_FFFF;
            3'd2: rd_mux = weight_ext;
            default: rd_mux = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_forex_result_reader.sv
// tb/tb_forex_result_reader.sv - directed self-checking bench for forex_result_reader

module tb_forex_result_reader;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    forex_result_reader_if #(.NODE_W(6), .WEIGHT_W(32)) bus ();

    forex_result_reader #(.NODE_W(6), .WEIGHT_W(32), .DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clk);
        d              = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic reg_write(input logic [2:0] a);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic send_beat(input int node, input bit last, input logic [31:0] w);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_node   = 6'(node);
        bus.in_last   = last;
        bus.in_weight = w;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("beat_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 3'd0;
        bus.in_valid   = 1'b0;
        bus.in_node    = 6'd0;
        bus.in_last    = 1'b0;
        bus.in_weight  = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_readdata", bus.readdata, 32'd0);
        check("rst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        reg_read(3'd0, d); check("rst_status", d, 32'h0000_0004);

        // Normal path 3,7,12 with weight -5
        send_beat(3, 1'b0, 32'hFFFF_FFFB);
        send_beat(7, 1'b0, 32'hFFFF_FFFB);
        send_beat(12, 1'b1, 32'hFFFF_FFFB);
        reg_read(3'd0, d); check("norm_status", d, 32'h0000_0301);
        reg_read(3'd2, d); check("norm_weight", d, 32'hFFFF_FFFB);
        reg_read(3'd1, d); check("norm_pop0", d, 32'd3);
        reg_read(3'd1, d); check("norm_pop1", d, 32'd7);
        reg_read(3'd1, d); check("norm_pop2", d, 32'd12);
        reg_read(3'd1, d); check("norm_pop_empty", d, 32'hFFFF_FFFF);
        reg_read(3'd0, d); check("norm_status_drained", d, 32'h0000_0005);

        // Backpressure in DONE, then clear lets the held beat in
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_node   = 6'd9;
        bus.in_last   = 1'b1;
        bus.in_weight = 32'hFFFF_FFFB;
        check("bp_ready_done", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("bp_ready_done_hold", {31'd0, bus.in_ready}, 32'd0);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 3'd3;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        check("bp_ready_after_clear", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("bp_ready_after_accept", {31'd0, bus.in_ready}, 32'd0);
        reg_read(3'd0, d); check("bp_status_one_beat", d, 32'h0000_0101);
        reg_read(3'd1, d); check("bp_pop", d, 32'd9);

        // Pop outside DONE
        reg_write(3'd3);
        send_beat(1, 1'b0, 32'd0);
        send_beat(2, 1'b0, 32'd0);
        reg_read(3'd1, d); check("fill_pop", d, 32'hFFFF_FFFF);
        reg_read(3'd0, d); check("fill_status", d, 32'h0000_0208);

        // Clear in the same cycle as a last beat
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_node    = 6'd33;
        bus.in_last    = 1'b1;
        bus.in_weight  = 32'd77;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = 3'd3;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.in_last    = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        reg_read(3'd0, d); check("sim_status", d, 32'h0000_0004);
        reg_read(3'd2, d); check("sim_weight_kept", d, 32'hFFFF_FFFB);

        // Read with no chipselect keeps readdata; unused address reads 0
        @(negedge clk);
        bus.read    = 1'b1;
        bus.address = 3'd0;
        @(negedge clk);
        bus.read    = 1'b0;
        check("nocs_readdata_held", bus.readdata, 32'hFFFF_FFFB);
        reg_read(3'd5, d); check("addr5_zero", d, 32'd0);

        // Overflow: 70 beats into 64 entries
        for (int i = 0; i < 70; i++) begin
            send_beat(i, (i == 69), 32'h0001_2345);
        end
        reg_read(3'd0, d); check("ovf_status", d, 32'h0000_4003);
        reg_read(3'd2, d); check("ovf_weight", d, 32'h0001_2345);
        for (int i = 0; i < 64; i++) begin
            reg_read(3'd1, d);
            check($sformatf("ovf_pop%0d", i), d, 32'(i));
        end
        reg_read(3'd1, d); check("ovf_pop_empty", d, 32'hFFFF_FFFF);
        reg_read(3'd0, d); check("ovf_status_drained", d, 32'h0000_0007);

        // Reset mid-drain
        reg_write(3'd3);
        send_beat(5, 1'b0, 32'd0);
        send_beat(6, 1'b0, 32'd0);
        send_beat(7, 1'b1, 32'd0);
        reg_read(3'd1, d); check("rmd_pop0", d, 32'd5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rmd_in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        check("rmd_readdata", bus.readdata, 32'd0);
        reg_read(3'd0, d); check("rmd_status", d, 32'h0000_0004);
        reg_read(3'd1, d); check("rmd_pop", d, 32'hFFFF_FFFF);
        reg_read(3'd2, d); check("rmd_weight", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
